// File: rtl/int_entry_sequencer_if.sv
// Handshake bundle between the interrupt controller, the pipeline and the
// interrupt entry sequencer.
interface int_entry_sequencer_if #(
   parameter int ADDR_W = 32
);
   logic              IntRequest;
   logic [1:0]        IntNum;
   logic              InstrBoundary;
   logic [ADDR_W-1:0] CurrentPC;
   logic              EretIn;
   logic              EI;
   logic              DI;
   logic              IntEnable;
   logic              INM0;
   logic              INM1;
   logic              INM2;
   logic              INM3;
   logic              EretOut;
   logic              Stall;
   logic              Redirect;
   logic [ADDR_W-1:0] RedirectPC;
   logic [2:0]        Depth;
   logic              Fault;

   // Environment side: controller and pipeline drive requests, observe control.
   modport master (
      output IntRequest, IntNum, InstrBoundary, CurrentPC, EretIn, EI, DI,
      input  IntEnable, INM0, INM1, INM2, INM3, EretOut, Stall, Redirect,
             RedirectPC, Depth, Fault
   );

   modport slave (
      input  IntRequest, IntNum, InstrBoundary, CurrentPC, EretIn, EI, DI,
      output IntEnable, INM0, INM1, INM2, INM3, EretOut, Stall, Redirect,
             RedirectPC, Depth, Fault
   );
endinterface

// File: rtl/int_entry_sequencer.sv
// Interrupt entry/return sequencer: saves return PC and level on a nesting
// stack, vectors fetch per level and drives the controller's mask/ERET inputs.
module int_entry_sequencer #(
   parameter int          ADDR_W        = 32,
   parameter int          DEPTH         = 4,
   parameter logic [31:0] VECTOR_BASE   = 32'h0000_3000,
   parameter logic [31:0] VECTOR_STRIDE = 32'h0000_0010
) (
   input logic                  clk,
   input logic                  clr_n,
   int_entry_sequencer_if.slave bus
);
   localparam int         IDX_W   = $clog2(DEPTH);
   localparam logic [2:0] DEPTH_C = 3'(DEPTH);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SAVE   = 2'd1,
      VECTOR = 2'd2,
      RETURN = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic              ie_q, ie_d;
   logic [2:0]        depth_q, depth_d;
   logic              fault_q, fault_d;
   logic [ADDR_W-1:0] pc_lat_q, pc_lat_d;
   logic [1:0]        lvl_lat_q, lvl_lat_d;
   logic              int_en_q, int_en_d;
   logic [3:0]        inm_q, inm_d;
   logic              eret_q, eret_d;
   logic              stall_q, stall_d;
   logic              redir_q, redir_d;
   logic [ADDR_W-1:0] rpc_q, rpc_d;
   logic              push_s;
   logic [ADDR_W-1:0] pc_stack_q [DEPTH];
   logic [1:0]        lvl_stack_q [DEPTH];

   // Masks every level at or below the one currently being serviced.
   function automatic logic [3:0] mask_upto(input logic [1:0] lvl);
      logic [3:0] m;
      case (lvl)
         2'd0:    m = 4'b0001;
         2'd1:    m = 4'b0011;
         2'd2:    m = 4'b0111;
         2'd3:    m = 4'b1111;
         default: m = 4'b1111;
      endcase
      return m;
   endfunction

   // Leaves only the returning level visible so the controller reports and clears it.
   function automatic logic [3:0] mask_return(input logic [1:0] lvl);
      return ~(4'b0001 << lvl);
   endfunction

   // Next-state and next-output computation for the sequencer.
   always_comb begin
      state_d   = state_q;
      ie_d      = ie_q;
      depth_d   = depth_q;
      fault_d   = fault_q;
      pc_lat_d  = pc_lat_q;
      lvl_lat_d = lvl_lat_q;
      inm_d     = inm_q;
      rpc_d     = rpc_q;
      eret_d    = 1'b0;
      stall_d   = 1'b0;
      redir_d   = 1'b0;
      push_s    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.DI) begin
               ie_d = 1'b0;
            end else if (bus.EI) begin
               ie_d = 1'b1;
            end else begin
               ie_d = ie_q;
            end
            if (bus.EretIn) begin
               if (depth_q != 3'd0) begin
                  state_d = RETURN;
                  stall_d = 1'b1;
                  redir_d = 1'b1;
                  eret_d  = 1'b1;
                  rpc_d   = pc_stack_q[IDX_W'(depth_q - 3'd1)];
                  inm_d   = mask_return(lvl_stack_q[IDX_W'(depth_q - 3'd1)]);
               end else begin
                  fault_d = 1'b1;
               end
            end else if (bus.IntRequest && int_en_q && bus.InstrBoundary) begin
               state_d   = SAVE;
               stall_d   = 1'b1;
               pc_lat_d  = bus.CurrentPC;
               lvl_lat_d = bus.IntNum;
            end else begin
               state_d = IDLE;
            end
         end
         SAVE: begin
            push_s  = 1'b1;
            depth_d = depth_q + 3'd1;
            state_d = VECTOR;
            stall_d = 1'b1;
            redir_d = 1'b1;
            rpc_d   = ADDR_W'(VECTOR_BASE + 32'(lvl_lat_q) * VECTOR_STRIDE);
         end
         VECTOR: begin
            state_d = IDLE;
            inm_d   = mask_upto(lvl_lat_q);
         end
         RETURN: begin
            depth_d = depth_q - 3'd1;
            state_d = IDLE;
            if (depth_q <= 3'd1) begin
               inm_d = 4'b0000;
            end else begin
               inm_d = mask_upto(lvl_stack_q[IDX_W'(depth_q - 3'd2)]);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      int_en_d = ie_d && (state_d == IDLE) && (depth_d < DEPTH_C);
   end

   // State, stack and registered outputs.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q   <= IDLE;
         ie_q      <= 1'b0;
         depth_q   <= 3'd0;
         fault_q   <= 1'b0;
         pc_lat_q  <= '0;
         lvl_lat_q <= 2'd0;
         int_en_q  <= 1'b0;
         inm_q     <= 4'b0000;
         eret_q    <= 1'b0;
         stall_q   <= 1'b0;
         redir_q   <= 1'b0;
         rpc_q     <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_stack_q[i]  <= '0;
            lvl_stack_q[i] <= 2'd0;
         end
      end else begin
         state_q   <= state_d;
         ie_q      <= ie_d;
         depth_q   <= depth_d;
         fault_q   <= fault_d;
         pc_lat_q  <= pc_lat_d;
         lvl_lat_q <= lvl_lat_d;
         int_en_q  <= int_en_d;
         inm_q     <= inm_d;
         eret_q    <= eret_d;
         stall_q   <= stall_d;
         redir_q   <= redir_d;
         rpc_q     <= rpc_d;
         if (push_s) begin
            pc_stack_q[IDX_W'(depth_q)]  <= pc_lat_q;
            lvl_stack_q[IDX_W'(depth_q)] <= lvl_lat_q;
         end else begin
            pc_stack_q  <= pc_stack_q;
            lvl_stack_q <= lvl_stack_q;
         end
      end
   end

   assign bus.IntEnable  = int_en_q;
   assign bus.INM0       = inm_q[0];
   assign bus.INM1       = inm_q[1];
   assign bus.INM2       = inm_q[2];
   assign bus.INM3       = inm_q[3];
   assign bus.EretOut    = eret_q;
   assign bus.Stall      = stall_q;
   assign bus.Redirect   = redir_q;
   assign bus.RedirectPC = rpc_q;
   assign bus.Depth      = depth_q;
   assign bus.Fault      = fault_q;
endmodule

// File: tb/tb_int_entry_sequencer.sv
// Directed bench for int_entry_sequencer: entry, nesting, ERET priority,
// fault, IE control and asynchronous reset during vectoring.
module tb_int_entry_sequencer;
   logic clk;
   logic clr_n;
   int   errors;
   int   checks;

   int_entry_sequencer_if #(.ADDR_W(32)) bus ();

   int_entry_sequencer dut (
      .clk   (clk),
      .clr_n (clr_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] inm();
      return {bus.INM3, bus.INM2, bus.INM1, bus.INM0};
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      bus.IntRequest    = 1'b0;
      bus.IntNum        = 2'd0;
      bus.InstrBoundary = 1'b0;
      bus.CurrentPC     = 32'h0;
      bus.EretIn        = 1'b0;
      bus.EI            = 1'b0;
      bus.DI            = 1'b0;
   endtask

   task automatic request(input logic [1:0] lvl, input logic [31:0] pc);
      bus.IntRequest    = 1'b1;
      bus.IntNum        = lvl;
      bus.InstrBoundary = 1'b1;
      bus.CurrentPC     = pc;
   endtask

   initial begin
      clk = 1'b0;
      clr_n = 1'b0;
      errors = 0;
      checks = 0;
      clear_inputs();
      tick();
      tick();
      chk("rst_stall", 32'(bus.Stall), 32'd0);
      chk("rst_redirect", 32'(bus.Redirect), 32'd0);
      chk("rst_rpc", bus.RedirectPC, 32'h0);
      chk("rst_inm", 32'(inm()), 32'h0);
      chk("rst_inten", 32'(bus.IntEnable), 32'd0);
      chk("rst_depth", 32'(bus.Depth), 32'd0);
      chk("rst_fault", 32'(bus.Fault), 32'd0);
      clr_n = 1'b1;

      // Test 1: single entry at level 2
      bus.EI = 1'b1;
      tick();
      chk("t1_inten", 32'(bus.IntEnable), 32'd1);
      bus.EI = 1'b0;
      request(2'd2, 32'h100);
      tick();
      chk("t1_save_stall", 32'(bus.Stall), 32'd1);
      chk("t1_save_redir", 32'(bus.Redirect), 32'd0);
      chk("t1_save_inten", 32'(bus.IntEnable), 32'd0);
      clear_inputs();
      tick();
      chk("t1_vec_redir", 32'(bus.Redirect), 32'd1);
      chk("t1_vec_rpc", bus.RedirectPC, 32'h3020);
      chk("t1_vec_depth", 32'(bus.Depth), 32'd1);
      tick();
      chk("t1_idle_redir", 32'(bus.Redirect), 32'd0);
      chk("t1_idle_stall", 32'(bus.Stall), 32'd0);
      chk("t1_idle_inm", 32'(inm()), 32'h7);

      // Test 2: nest level 3, then unwind with two ERETs
      request(2'd3, 32'h3024);
      tick();
      clear_inputs();
      tick();
      chk("t2_vec_rpc", bus.RedirectPC, 32'h3030);
      chk("t2_vec_depth", 32'(bus.Depth), 32'd2);
      tick();
      chk("t2_inm", 32'(inm()), 32'hF);
      bus.EretIn = 1'b1;
      tick();
      chk("t2_ret1_redir", 32'(bus.Redirect), 32'd1);
      chk("t2_ret1_rpc", bus.RedirectPC, 32'h3024);
      chk("t2_ret1_eret", 32'(bus.EretOut), 32'd1);
      chk("t2_ret1_inm", 32'(inm()), 32'h7);
      bus.EretIn = 1'b0;
      tick();
      chk("t2_ret1_depth", 32'(bus.Depth), 32'd1);
      chk("t2_ret1_eretoff", 32'(bus.EretOut), 32'd0);
      chk("t2_ret1_inm_after", 32'(inm()), 32'h7);
      bus.EretIn = 1'b1;
      tick();
      chk("t2_ret2_rpc", bus.RedirectPC, 32'h100);
      chk("t2_ret2_inm", 32'(inm()), 32'hB);
      bus.EretIn = 1'b0;
      tick();
      chk("t2_ret2_depth", 32'(bus.Depth), 32'd0);
      chk("t2_ret2_inm_after", 32'(inm()), 32'h0);

      // Test 3: ERET beats a same-cycle interrupt
      request(2'd1, 32'h200);
      tick();
      clear_inputs();
      tick();
      chk("t3_vec_rpc", bus.RedirectPC, 32'h3010);
      tick();
      chk("t3_inm", 32'(inm()), 32'h3);
      request(2'd2, 32'h240);
      bus.EretIn = 1'b1;
      tick();
      chk("t3_ret_rpc", bus.RedirectPC, 32'h200);
      chk("t3_ret_eret", 32'(bus.EretOut), 32'd1);
      bus.EretIn = 1'b0;
      tick();
      chk("t3_idle_depth", 32'(bus.Depth), 32'd0);
      chk("t3_idle_stall", 32'(bus.Stall), 32'd0);
      tick();
      chk("t3_late_save", 32'(bus.Stall), 32'd1);
      clear_inputs();
      tick();
      chk("t3_late_rpc", bus.RedirectPC, 32'h3020);
      chk("t3_late_depth", 32'(bus.Depth), 32'd1);
      tick();
      bus.EretIn = 1'b1;
      tick();
      bus.EretIn = 1'b0;
      tick();
      chk("t3_back_depth", 32'(bus.Depth), 32'd0);

      // Test 4: ERET with empty stack is a sticky fault
      bus.EretIn = 1'b1;
      tick();
      chk("t4_no_redir", 32'(bus.Redirect), 32'd0);
      chk("t4_fault", 32'(bus.Fault), 32'd1);
      bus.EretIn = 1'b0;
      request(2'd0, 32'h300);
      tick();
      clear_inputs();
      tick();
      chk("t4_vec_rpc", bus.RedirectPC, 32'h3000);
      tick();
      chk("t4_inm", 32'(inm()), 32'h1);
      bus.EretIn = 1'b1;
      tick();
      bus.EretIn = 1'b0;
      tick();
      chk("t4_fault_sticky", 32'(bus.Fault), 32'd1);
      clr_n = 1'b0;
      tick();
      chk("t4_fault_cleared", 32'(bus.Fault), 32'd0);
      clr_n = 1'b1;

      // Test 5: DI beats EI; no entry without an instruction boundary
      bus.EI = 1'b1;
      bus.DI = 1'b1;
      tick();
      chk("t5_di_wins", 32'(bus.IntEnable), 32'd0);
      bus.DI = 1'b0;
      tick();
      chk("t5_ei", 32'(bus.IntEnable), 32'd1);
      bus.EI = 1'b0;
      request(2'd1, 32'h400);
      bus.InstrBoundary = 1'b0;
      tick();
      tick();
      chk("t5_no_boundary", 32'(bus.Stall), 32'd0);
      bus.InstrBoundary = 1'b1;
      tick();
      chk("t5_boundary_save", 32'(bus.Stall), 32'd1);
      clear_inputs();
      tick();
      chk("t5_vec_redir", 32'(bus.Redirect), 32'd1);

      // Test 6: asynchronous reset during VECTOR
      clr_n = 1'b0;
      #1;
      chk("t6_redir", 32'(bus.Redirect), 32'd0);
      chk("t6_stall", 32'(bus.Stall), 32'd0);
      chk("t6_rpc", bus.RedirectPC, 32'h0);
      chk("t6_depth", 32'(bus.Depth), 32'd0);
      tick();
      clr_n = 1'b1;
      tick();
      chk("t6_after_redir", 32'(bus.Redirect), 32'd0);
      chk("t6_after_inm", 32'(inm()), 32'h0);
      chk("t6_after_inten", 32'(bus.IntEnable), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/int_entry_sequencer.md
Name: int_entry_sequencer

Overview:
- Sits directly downstream of the 4-source interrupt controller and consumes its IntRequest/IntNum.
- Takes an interrupt at an instruction boundary: stalls the pipeline, pushes the return PC and level onto a nesting stack, and redirects fetch to a per-level vector.
- Drives the controller's IntEnable, INM0-3 and ERET inputs, so pending bits are cleared for the exact level being returned from.
- Allows nesting only by strictly higher priorities.

Parameters:
ADDR_W, 32, PC width
DEPTH, 4, nesting stack entries (one per priority level)
VECTOR_BASE, 32'h0000_3000, vector address of level 0
VECTOR_STRIDE, 32'h10, byte distance between level vectors

Ports:
clk  in  1  system clock, rising edge
clr_n  in  1  asynchronous active-low reset
IntRequest  in  1  unmasked, enabled request from interrupt controller
IntNum  in  2  highest-priority pending level from controller
InstrBoundary  in  1  pipeline may be interrupted this cycle
CurrentPC  in  ADDR_W  return address if interrupt taken this cycle
EretIn  in  1  ERET instruction executing (1-cycle pulse)
EI  in  1  set IE bit
DI  in  1  clear IE bit
IntEnable  out  1  to controller
INM0..INM3  out  1 each  mask bits to controller
EretOut  out  1  ERET pulse to controller
Stall  out  1  hold pipeline
Redirect  out  1  1-cycle fetch redirect strobe
RedirectPC  out  ADDR_W  redirect target
Depth  out  3  current nesting depth, 0..DEPTH
Fault  out  1  sticky: ERET at depth 0

Behaviour:
- Reset (clr_n low, async): state IDLE; IE=0; Depth=0; stack cleared; Fault=0; all outputs 0 (INM0-3=0, IntEnable=0, Stall=0, Redirect=0, EretOut=0, RedirectPC=0).
- IE bit: DI wins over EI if both are high; update on the clock edge. IntEnable = IE & state==IDLE & Depth<DEPTH.
- Masks in IDLE: Depth=0 -> all INM=0. Otherwise top level L -> INMk=1 for all k<=L.
- States: IDLE, SAVE, VECTOR, RETURN.
- IDLE -> SAVE when EretIn=0 & IntRequest & IntEnable & InstrBoundary (cycle T).
  - At T: latch CurrentPC and IntNum.
- SAVE (T+1):
  - Stall=1, IntEnable=0.
  - Push {PC, level}; Depth++.
- VECTOR (T+2):
  - Stall=1, Redirect=1, RedirectPC = VECTOR_BASE + level*VECTOR_STRIDE.
  - Then -> IDLE.
  - New masks are in effect from T+3.
- IDLE with EretIn=1:
  - Depth>0 -> RETURN. EretIn has priority over a same-cycle interrupt.
  - Depth=0 -> ignored, Fault set (sticky until reset), stay IDLE.
- RETURN (one cycle):
  - Stall=1, Redirect=1, RedirectPC = top PC.
  - INM = all ones except the returning level L, and EretOut=1, so the controller's IntNum equals L and clears it.
  - Pop; Depth--; -> IDLE.
- Stall=0 and Redirect=0 in IDLE.
- Entry latency: 2 cycles from acceptance to Redirect. ERET latency: 1 cycle.
- Inputs other than clr_n are ignored outside IDLE.
- Depth==DEPTH holds IntEnable at 0, so the stack cannot overflow.
- Reset mid-sequence: returns to IDLE immediately; stack contents are discarded.

Test Plan:
1. Reset, EI=1, IntRequest=1, IntNum=2, InstrBoundary=1, CurrentPC=0x100 -> SAVE, then Redirect with RedirectPC=0x3020 two cycles later; Depth=1; INM0-2=1, INM3=0.
2. Nesting:
   - From test 1, take level 3 with CurrentPC=0x3024 -> RedirectPC=0x3030, Depth=2, all INM=1.
   - ERET -> RedirectPC=0x3024, EretOut=1 with INM=4'b0111.
   - Second ERET -> RedirectPC=0x100, Depth=0, INM=0.
3. EretIn and IntRequest high in the same IDLE cycle at Depth=1 -> RETURN taken, interrupt not accepted; interrupt accepted later if still requested.
4. EretIn at Depth=0 -> no Redirect, Fault=1, still 1 after further activity until clr_n low.
5. EI=DI=1 -> IE=0, IntEnable=0; IntRequest with InstrBoundary=0 -> no entry until boundary.
6. Assert clr_n low during VECTOR -> all outputs 0 asynchronously, Depth=0, no Redirect pulse.
